// File: rtl/arm_bus_slave_if.sv
// HPS master-port bus bundle: word read/write with waitrequest flow control.
interface arm_bus_slave_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] slave_addr_i;
    logic                  slave_wr_i;
    logic                  slave_rd_i;
    logic [31:0]           slave_datawr_i;
    logic [31:0]           slave_datard_o;
    logic                  slave_waitreq_o;

    modport master (
        output slave_addr_i, slave_wr_i, slave_rd_i, slave_datawr_i,
        input  slave_datard_o, slave_waitreq_o
    );

    modport slave (
        input  slave_addr_i, slave_wr_i, slave_rd_i, slave_datawr_i,
        output slave_datard_o, slave_waitreq_o
    );
endinterface

// File: rtl/arm_bus_slave.sv
// HPS bus responder holding NUM_REGS parameter registers with per-register write strobes.
// Define ARM_BUS_SLAVE_FRAMECNT_EN to add a read-only frame counter at index NUM_REGS.
module arm_bus_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                     clk_proc,
    input  logic                     reset,
    arm_bus_slave_if.slave           bus,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      reg_wr_o,
    input  logic                     in_fv
);

`ifdef ARM_BUS_SLAVE_FRAMECNT_EN
    localparam int NUM_SLOTS = NUM_REGS + 1;
`else
    localparam int NUM_SLOTS = NUM_REGS;
`endif
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [NUM_REGS-1:0][31:0] regs_q;
    logic [ADDR_WIDTH-1:0]     addr_index;
    logic                      addr_hit;
    logic [IDX_W-1:0]          addr_idx;
    logic                      wr_hit;

    logic [1:0]                state;
    logic [3:0]                wcnt;
    logic [IDX_W-1:0]          rd_idx;
    logic                      rd_hit;
    logic [IDX_W-1:0]          sel_idx;
    logic                      sel_hit;
    logic [31:0]               rd_value;
    logic [31:0]               rd_data;
    logic [31:0]               frame_cnt;

    // Subtraction wraps modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR land far out of range.
    assign addr_index = (bus.slave_addr_i - BASE_ADDR) >> 2;
    assign addr_hit   = addr_index < ADDR_WIDTH'(NUM_SLOTS);
    assign addr_idx   = addr_index[IDX_W-1:0];
    assign wr_hit     = bus.slave_wr_i && addr_hit;

    // NOTE: the register bank is reset like any other state; downstream blocks see defined parameters.
    always_ff @(posedge clk_proc) begin
        if (reset) begin
            regs_q   <= '0;
            reg_wr_o <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout sequential logic, so every read sees pre-edge values.
            reg_wr_o <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_hit && addr_idx == IDX_W'(k)) begin
                    regs_q[k]   <= bus.slave_datawr_i;
                    reg_wr_o[k] <= 1'b1;
                end
            end
        end
    end

    assign regs_o = regs_q;

`ifdef ARM_BUS_SLAVE_FRAMECNT_EN
    logic fv_q;

    // A clear in the same cycle as an in_fv rising edge wins.
    always_ff @(posedge clk_proc) begin
        if (reset) begin
            fv_q      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            fv_q <= in_fv;
            if (wr_hit && addr_idx == IDX_W'(NUM_REGS)) begin
                frame_cnt <= '0;
            end else if (in_fv && !fv_q) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_in_fv;

    assign frame_cnt    = '0;
    assign unused_in_fv = in_fv;
`endif

    // With zero wait states RESP is entered straight from IDLE, so sample the live address there.
    assign sel_idx = (state == ST_IDLE) ? addr_idx : rd_idx;
    assign sel_hit = (state == ST_IDLE) ? addr_hit : rd_hit;

    // NOTE: rd_value gets a default before any branch, so no latch is inferred.
    always_comb begin
        rd_value = '0;
        if (sel_hit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (sel_idx == IDX_W'(k)) rd_value = regs_q[k];
            end
            if (NUM_SLOTS > NUM_REGS && sel_idx == IDX_W'(NUM_REGS)) rd_value = frame_cnt;
        end
    end

    always_ff @(posedge clk_proc) begin
        if (reset) begin
            state   <= ST_IDLE;
            wcnt    <= '0;
            rd_idx  <= '0;
            rd_hit  <= 1'b0;
            rd_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.slave_rd_i && !bus.slave_wr_i) begin
                        rd_idx <= addr_idx;
                        rd_hit <= addr_hit;
                        if (WAIT_STATES == 0) begin
                            state   <= ST_RESP;
                            rd_data <= rd_value;
                        end else begin
                            state <= ST_WAIT;
                            wcnt  <= 4'(WAIT_STATES);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!bus.slave_rd_i) begin
                        state <= ST_IDLE;
                        wcnt  <= '0;
                    end else if (wcnt == 4'd1) begin
                        state   <= ST_RESP;
                        wcnt    <= '0;
                        rd_data <= rd_value;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A write issued together with a read from IDLE wins and must not stall the master.
    assign bus.slave_waitreq_o = bus.slave_rd_i && (state != ST_RESP)
                                 && !(state == ST_IDLE && bus.slave_wr_i);
    assign bus.slave_datard_o  = rd_data;

endmodule

// File: tb/tb_arm_bus_slave.sv
// Self-checking bench: two responders (1 and 4 wait states) share stimulus against a register model.
module tb_arm_bus_slave;
    localparam int          NR   = 16;
    localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef ARM_BUS_SLAVE_FRAMECNT_EN
    localparam bit FCNT = 1'b1;
`else
    localparam bit FCNT = 1'b0;
`endif

    logic clk_proc = 1'b0;
    logic reset    = 1'b1;
    logic in_fv    = 1'b0;

    always #5 clk_proc = ~clk_proc;

    arm_bus_slave_if #(.ADDR_WIDTH(32)) bus_a ();
    arm_bus_slave_if #(.ADDR_WIDTH(32)) bus_b ();

    logic [NR*32-1:0] regs_a, regs_b;
    logic [NR-1:0]    strb_a, strb_b;

    arm_bus_slave #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(1)) dut_a (
        .clk_proc(clk_proc), .reset(reset), .bus(bus_a),
        .regs_o(regs_a), .reg_wr_o(strb_a), .in_fv(in_fv)
    );

    arm_bus_slave #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(4)) dut_b (
        .clk_proc(clk_proc), .reset(reset), .bus(bus_b),
        .regs_o(regs_b), .reg_wr_o(strb_b), .in_fv(in_fv)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [NR];
    logic [31:0] fcnt  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slot_of(input logic [31:0] addr);
        return (addr - BASE) >> 2;
    endfunction

    function automatic logic [NR*32-1:0] model_vec();
        logic [NR*32-1:0] v;
        for (int k = 0; k < NR; k++) v[k*32 +: 32] = model[k];
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] s;
        s = slot_of(addr);
        if (s < NR) return model[s];
        if (FCNT && s == NR) return fcnt;
        return 32'h0;
    endfunction

    task automatic set_bus(input logic [31:0] addr, input logic [31:0] data,
                           input logic rd, input logic wr);
        bus_a.slave_addr_i = addr; bus_a.slave_datawr_i = data;
        bus_a.slave_rd_i   = rd;   bus_a.slave_wr_i     = wr;
        bus_b.slave_addr_i = addr; bus_b.slave_datawr_i = data;
        bus_b.slave_rd_i   = rd;   bus_b.slave_wr_i     = wr;
    endtask

    task automatic next_cycle();
        @(posedge clk_proc);
        #1;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic with_rd, input string tag);
        logic [31:0]   s;
        logic [NR-1:0] exp_strb;
        set_bus(addr, data, with_rd, 1'b1);
        @(negedge clk_proc);
        check({tag, "_wq_a"}, 64'(bus_a.slave_waitreq_o), 64'd0);
        check({tag, "_wq_b"}, 64'(bus_b.slave_waitreq_o), 64'd0);
        next_cycle();
        set_bus('0, '0, 1'b0, 1'b0);
        s        = slot_of(addr);
        exp_strb = '0;
        if (s < NR) begin
            model[s] = data;
            exp_strb = NR'(1) << s;
        end else if (FCNT && s == NR) begin
            fcnt = '0;
        end
        @(negedge clk_proc);
        check({tag, "_regs_a"}, 64'(regs_a === model_vec()), 64'd1);
        check({tag, "_regs_b"}, 64'(regs_b === model_vec()), 64'd1);
        check({tag, "_strb_a"}, 64'(strb_a), 64'(exp_strb));
        check({tag, "_strb_b"}, 64'(strb_b), 64'(exp_strb));
        next_cycle();
        @(negedge clk_proc);
        check({tag, "_strb_off"}, 64'({strb_a, strb_b}), 64'd0);
        next_cycle();
    endtask

    task automatic do_read(input logic [31:0] addr, input string tag);
        logic [31:0] exp, got_a, got_b;
        int          na, nb, cyc;
        logic        da, db;
        exp = model_read(addr);
        na = 0; nb = 0; cyc = 0; da = 1'b0; db = 1'b0;
        got_a = 'x; got_b = 'x;
        set_bus(addr, '0, 1'b1, 1'b0);
        while (!(da && db) && cyc < 40) begin
            @(negedge clk_proc);
            if (!da) begin
                if (!bus_a.slave_waitreq_o) begin da = 1'b1; got_a = bus_a.slave_datard_o; end
                else na++;
            end
            if (!db) begin
                if (!bus_b.slave_waitreq_o) begin db = 1'b1; got_b = bus_b.slave_datard_o; end
                else nb++;
            end
            next_cycle();
            if (da) bus_a.slave_rd_i = 1'b0;
            if (db) bus_b.slave_rd_i = 1'b0;
            cyc++;
        end
        set_bus('0, '0, 1'b0, 1'b0);
        check({tag, "_done"},   64'({da, db}), 64'b11);
        check({tag, "_lat_a"},  64'(na), 64'd2);
        check({tag, "_lat_b"},  64'(nb), 64'd5);
        check({tag, "_data_a"}, 64'(got_a), 64'(exp));
        check({tag, "_data_b"}, 64'(got_b), 64'(exp));
        check({tag, "_regs"},   64'(regs_a === model_vec() && regs_b === model_vec()), 64'd1);
    endtask

    initial begin
        for (int k = 0; k < NR; k++) model[k] = '0;
        set_bus('0, '0, 1'b1, 1'b0);
        repeat (3) next_cycle();
        @(negedge clk_proc);
        check("rst_wq_follows_rd", 64'({bus_a.slave_waitreq_o, bus_b.slave_waitreq_o}), 64'b11);
        check("rst_datard", 64'({bus_a.slave_datard_o, bus_b.slave_datard_o}), 64'd0);
        check("rst_regs", 64'(regs_a === '0 && regs_b === '0), 64'd1);
        check("rst_strb", 64'({strb_a, strb_b}), 64'd0);
        next_cycle();
        reset = 1'b0;
        set_bus('0, '0, 1'b0, 1'b0);
        next_cycle();

        do_read(BASE + 32'd12, "rd_idx3");
        do_write(BASE + 32'd8, 32'hA5A5_0001, 1'b0, "wr_idx2");
        check("wr_idx2_slice", 64'(regs_a[95:64]), 64'hA5A5_0001);
        do_read(BASE + 32'd8, "rd_idx2");
        do_read(BASE + 32'(4 * NR + 4), "rd_oor");
        do_write(BASE, 32'h0000_1234, 1'b1, "rdwr_idx0");
        do_read(BASE, "rd_idx0");
        do_write(BASE - 32'd4, 32'hDEAD_BEEF, 1'b0, "wr_below_base");

        // Abort a read in its wait phase, then re-issue it from a clean IDLE.
        do_write(BASE + 32'd20, 32'h5555_AAAA, 1'b0, "wr_idx5");
        set_bus(BASE + 32'd20, '0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < NR; k++) model[k] = '0;
        fcnt = '0;
        do_read(BASE + 32'd20, "rd_after_rst");

        if (FCNT) begin
            repeat (3) begin
                in_fv = 1'b1;
                next_cycle(); next_cycle();
                in_fv = 1'b0;
                next_cycle(); next_cycle();
            end
            fcnt = fcnt + 32'd3;
            do_read(BASE + 32'(4 * NR), "rd_fcnt");
            do_write(BASE + 32'(4 * NR), $urandom(), 1'b0, "wr_fcnt_clr");
            do_read(BASE + 32'(4 * NR), "rd_fcnt_clr");
        end

        for (int i = 0; i < 30; i++) begin
            logic [31:0] addr;
            int          kind;
            addr = BASE + 32'($urandom_range(0, NR + 1) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = BASE - 32'($urandom_range(1, 64));
            kind = $urandom_range(0, 2);
            case (kind)
                0:       do_write(addr, $urandom(), 1'b0, "rnd_wr");
                1:       do_write(addr, $urandom(), 1'b1, "rnd_rdwr");
                default: do_read(addr, "rnd_rd");
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
